// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO round-robin write arbiter.
// Imported by fifo_rr_arbiter and its test environment.
package fifo_arb_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam int DATA_W = 8;
    localparam int STAT_W = 16;

    // Counter width able to hold 0..entries inclusive.
    function automatic int occ_w(input int entries);
        return $clog2(entries) + 1;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr.sv
// Round-robin grant generator with its own rotating priority pointer.
// The pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] prio_q;
    logic [PW-1:0] prio_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt    = '0;
        prio_d = prio_q;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(prio_q) + i) % NUM_REQ;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                prio_d   = PW'((idx + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Multi-producer write arbiter and pop/flush sequencer for a shared FIFO.
// Define FIFO_RR_ARBITER_STATS_EN to add per-producer grant counters.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ENTRIES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        pop_req,
    output logic                        pop_valid,
    output logic [DATA_W-1:0]           pop_data,
    input  logic                        flush,
    output logic                        busy,
    output logic [occ_w(ENTRIES)-1:0]   occupancy,
    output logic                        fifo_write_ctrl,
    output logic [DATA_W-1:0]           fifo_write_data,
    output logic                        fifo_read_ctrl,
    input  logic [DATA_W-1:0]           fifo_read_data
`ifdef FIFO_RR_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]   grant_count
`endif
);

    localparam int OW = occ_w(ENTRIES);
    localparam logic [OW-1:0] FULL = OW'(ENTRIES);

    state_e        state_q;
    state_e        state_d;
    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;
    logic          pv_q;
    logic          pv_d;
    logic          grant_en;
    logic          wr;
    logic          rd;

    // A same-cycle read never frees room for that cycle's write.
    assign grant_en = !rst && (state_q == RUN) && (occ_q < FULL);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .en  (grant_en),
        .gnt (req_ready)
    );

    assign wr = |req_ready;

    always_comb begin
        rd = 1'b0;
        if (!rst) begin
            unique case (state_q)
                RUN:     rd = pop_req && (occ_q != '0);
                FLUSH:   rd = (occ_q != '0);
                default: rd = 1'b0;
            endcase
        end
    end

    always_comb begin
        fifo_write_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                fifo_write_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        unique case ({wr, rd})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Flushed reads are drained silently.
    assign pv_d = (state_q == RUN) && rd;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (flush) state_d = FLUSH;
            end
            FLUSH: begin
                if (occ_q == '0 && !flush) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            occ_q   <= '0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            pv_q    <= pv_d;
        end
    end

    assign fifo_write_ctrl = wr;
    assign fifo_read_ctrl  = rd;
    assign pop_valid       = pv_q;
    assign pop_data        = fifo_read_data;
    assign busy            = (state_q == FLUSH);
    assign occupancy       = occ_q;

`ifdef FIFO_RR_ARBITER_STATS_EN
    logic [STAT_W-1:0] cnt_q [NUM_REQ];
    logic [STAT_W-1:0] cnt_d [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (req_ready[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_count[i*STAT_W +: STAT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench: cycle model + data scoreboard for fifo_rr_arbiter.
module tb_fifo_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        pop_req;
    logic        pop_valid;
    logic [7:0]  pop_data;
    logic        flush;
    logic        busy;
    logic [2:0]  occupancy;
    logic        fifo_write_ctrl;
    logic [7:0]  fifo_write_data;
    logic        fifo_read_ctrl;
    logic [7:0]  fifo_read_data;
`ifdef FIFO_RR_ARBITER_STATS_EN
    logic [63:0] grant_count;
    logic [63:0] gc_snap;
`endif

    always #5 clk = ~clk;

    fifo_rr_arbiter #(
        .NUM_REQ (4),
        .ENTRIES (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .pop_req         (pop_req),
        .pop_valid       (pop_valid),
        .pop_data        (pop_data),
        .flush           (flush),
        .busy            (busy),
        .occupancy       (occupancy),
        .fifo_write_ctrl (fifo_write_ctrl),
        .fifo_write_data (fifo_write_data),
        .fifo_read_ctrl  (fifo_read_ctrl),
        .fifo_read_data  (fifo_read_data)
`ifdef FIFO_RR_ARBITER_STATS_EN
        ,
        .grant_count     (grant_count)
`endif
    );

    // Attached FIFO with registered read data.
    logic [7:0] mem [4];
    logic [1:0] wp;
    logic [1:0] rp;

    always @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            fifo_read_data <= '0;
        end else begin
            if (fifo_write_ctrl) begin
                mem[wp] <= fifo_write_data;
                wp <= wp + 1'b1;
            end
            if (fifo_read_ctrl) begin
                fifo_read_data <= mem[rp];
                rp <= rp + 1'b1;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model state.
    logic       m_flush_st = 1'b0;
    int         m_occ = 0;
    int         m_prio = 0;
    logic       m_pv = 1'b0;
    logic [7:0] sb [$];
    logic [7:0] pend [$];

    logic [3:0] seen_gnt;
    logic       seen_rd;
    logic       seen_pv;
    logic [7:0] seen_pd;

    task automatic tick();
        logic [3:0] eg;
        logic       ewr;
        logic       erd;
        logic [7:0] ed;
        logic [7:0] junk;
        int         g;
        int         k;
        @(negedge clk);
        eg = '0;
        g = -1;
        ed = '0;
        if (!rst && !m_flush_st && m_occ < 4) begin
            for (int i = 0; i < 4; i++) begin
                k = (m_prio + i) % 4;
                if (g < 0 && req_valid[k]) begin
                    g = k;
                    eg[k] = 1'b1;
                end
            end
        end
        ewr = (g >= 0);
        if (ewr) ed = req_data[g*8 +: 8];
        erd = !rst && (m_flush_st ? (m_occ > 0) : (pop_req && m_occ > 0));
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("wr_ctrl", 32'(fifo_write_ctrl), 32'(ewr));
        chk("wr_data", 32'(fifo_write_data), 32'(ed));
        chk("rd_ctrl", 32'(fifo_read_ctrl), 32'(erd));
        chk("busy", 32'(busy), 32'(m_flush_st));
        chk("pop_valid", 32'(pop_valid), 32'(m_pv));
        chk("occupancy", 32'(occupancy), 32'(m_occ));
        if (m_pv && pend.size() > 0) begin
            chk("pop_data", 32'(pop_data), 32'(pend.pop_front()));
        end
        seen_gnt = req_ready;
        seen_rd = fifo_read_ctrl;
        seen_pv = pop_valid;
        seen_pd = pop_data;
        @(posedge clk);
        if (rst) begin
            m_flush_st = 1'b0;
            m_occ = 0;
            m_prio = 0;
            m_pv = 1'b0;
            sb.delete();
            pend.delete();
        end else begin
            if (erd && sb.size() > 0) begin
                junk = sb.pop_front();
                if (!m_flush_st) pend.push_back(junk);
            end
            if (ewr) begin
                sb.push_back(ed);
                m_prio = (g + 1) % 4;
            end
            m_occ = m_occ + (ewr ? 1 : 0) - (erd ? 1 : 0);
            m_pv = !m_flush_st && erd;
            if (!m_flush_st) begin
                if (flush) m_flush_st = 1'b1;
            end else if (m_occ + (erd ? 1 : 0) == 0 && !flush) begin
                m_flush_st = 1'b0;
            end
        end
        #1;
    endtask

    int rd_n;
    int pv_n;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        pop_req = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pv", 32'(pop_valid), 0);
`ifdef FIFO_RR_ARBITER_STATS_EN
        chk("rst_gc", grant_count[31:0], 0);
`endif

        // 1: all producers, fill to full
        req_valid = 4'hF;
        req_data = 32'h13121110;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_gnt", 32'(seen_gnt), 32'(1 << i));
            chk("t1_occ", 32'(occupancy), 32'(i + 1));
        end
        tick();
        chk("t1_full_gnt", 32'(seen_gnt), 0);
        req_valid = '0;

        // 2: pop everything plus one extra
        pop_req = 1'b1;
        rd_n = 0;
        pv_n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (seen_rd) rd_n++;
            if (seen_pv) begin
                chk("t2_data", 32'(seen_pd), 32'(8'h10 + pv_n));
                pv_n++;
            end
        end
        chk("t2_reads", 32'(rd_n), 4);
        chk("t2_pvs", 32'(pv_n), 4);
        chk("t2_occ", 32'(occupancy), 0);
        pop_req = 1'b0;

        // 3: producers 0 and 2 with continuous pops
        req_valid = 4'b0101;
        req_data = 32'h23222120;
        pop_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t3_gnt", 32'(seen_gnt), (i % 2 == 0) ? 32'h1 : 32'h4);
            chk("t3_occ", 32'(occupancy), 1);
        end
        req_valid = '0;
        tick();
        tick();
        pop_req = 1'b0;
        chk("t3_drain", 32'(occupancy), 0);

        // 4: simultaneous write/read at 2, then at full
        req_valid = 4'b0001;
        req_data = 32'h000000A0;
        tick();
        req_data = 32'h000000A1;
        tick();
        chk("t4_occ2", 32'(occupancy), 2);
        req_data = 32'h000000A2;
        pop_req = 1'b1;
        tick();
        chk("t4_both_gnt", 32'(seen_gnt), 1);
        chk("t4_both_rd", 32'(seen_rd), 1);
        chk("t4_occ_hold", 32'(occupancy), 2);
        pop_req = 1'b0;
        req_data = 32'h000000A3;
        tick();
        req_data = 32'h000000A4;
        tick();
        chk("t4_occ4", 32'(occupancy), 4);
        pop_req = 1'b1;
        tick();
        chk("t4_full_gnt", 32'(seen_gnt), 0);
        chk("t4_full_rd", 32'(seen_rd), 1);
        chk("t4_occ3", 32'(occupancy), 3);
        pop_req = 1'b0;
        req_valid = '0;
        tick();

        // 5: flush pulse at occupancy 3
`ifdef FIFO_RR_ARBITER_STATS_EN
        gc_snap = grant_count;
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_busy", 32'(busy), 1);
        rd_n = 0;
        pv_n = 0;
        for (int i = 0; i < 10 && busy; i++) begin
            tick();
            if (seen_rd) rd_n++;
            if (seen_pv) pv_n++;
        end
        chk("t5_reads", 32'(rd_n), 3);
        chk("t5_pvs", 32'(pv_n), 0);
        chk("t5_occ", 32'(occupancy), 0);
        chk("t5_run", 32'(busy), 0);
`ifdef FIFO_RR_ARBITER_STATS_EN
        chk("t5_gc", grant_count[31:0], gc_snap[31:0]);
        chk("t5_gc_hi", grant_count[63:32], gc_snap[63:32]);
`endif

        // 6: reset in the middle of a flush
        req_valid = 4'b0010;
        req_data = 32'h0000B000;
        tick();
        tick();
        tick();
        req_valid = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("t6_occ2", 32'(occupancy), 2);
        chk("t6_busy", 32'(busy), 1);
        rst = 1'b1;
        req_valid = 4'hF;
        req_data = 32'hC3C2C1C0;
        pop_req = 1'b1;
        tick();
        chk("t6_rst_gnt", 32'(seen_gnt), 0);
        chk("t6_rst_rd", 32'(seen_rd), 0);
        rst = 1'b0;
        pop_req = 1'b0;
        chk("t6_occ", 32'(occupancy), 0);
        chk("t6_busy0", 32'(busy), 0);
        chk("t6_pv", 32'(pop_valid), 0);
`ifdef FIFO_RR_ARBITER_STATS_EN
        chk("t6_gc", grant_count[31:0], 0);
`endif
        tick();
        chk("t6_prio", 32'(seen_gnt), 1);
        req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
